// File: rtl/multi_player_control_if.sv
// Map tile read port between multi_player_control (master) and the map store (slave).
// Fixed-latency strobe protocol, no backpressure.
interface multi_player_control_if #(
  parameter int COORD_W = 8,
  parameter int TILE_W  = 3
);
  // map_rd_en is a one-cycle request strobe (no ready). The slave must accept every
  // strobe and present map_rd_tile exactly MAP_RD_LAT cycles later. Only the most
  // recent strobe's result is meaningful.
  logic               map_rd_en;
  logic [COORD_W-1:0] map_rd_x;
  logic [COORD_W-1:0] map_rd_y;
  logic [TILE_W-1:0]  map_rd_tile;

  modport master (output map_rd_en, map_rd_x, map_rd_y, input map_rd_tile);
  modport slave  (input map_rd_en, map_rd_x, map_rd_y, output map_rd_tile);
endinterface

// File: rtl/multi_player_control.sv
// Tick-paced movement and collision controller for N players on a tile map.
// Optional CONTROL_WRAP_EN: off-map targets wrap to the opposite edge instead of colliding.
module multi_player_control #(
  parameter int N_PLAYERS  = 2,
  parameter int COORD_W    = 8,
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30,
  parameter int TICK_DIV   = 16_250_000,
  parameter int MAP_RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt,
  input  logic [N_PLAYERS-1:0]         enable,
  input  logic [N_PLAYERS*3-1:0]       direction,
  input  logic [N_PLAYERS*COORD_W-1:0] start_x,
  input  logic [N_PLAYERS*COORD_W-1:0] start_y,
  multi_player_control_if.master       map,
  output logic [N_PLAYERS*COORD_W-1:0] pos_x,
  output logic [N_PLAYERS*COORD_W-1:0] pos_y,
  output logic [N_PLAYERS-1:0]         collision,
  output logic                         step_done,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [2:0] DIR_RIGHT  = 3'd1;
  localparam logic [2:0] DIR_LEFT   = 3'd2;
  localparam logic [2:0] DIR_DOWN   = 3'd3;
  localparam logic [2:0] DIR_UP     = 3'd4;
  localparam logic [2:0] TILE_EMPTY = 3'd0;

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] MAP_W_C  = COORD_W'(MAP_W);
  localparam logic [COORD_W-1:0] MAP_H_C  = COORD_W'(MAP_H);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PLAYERS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [1:0]         LAT_LAST = 2'(MAP_RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_EVAL      = 3'd2,
    S_READ      = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               tick_pend;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lat_cnt;
  logic [COORD_W-1:0] px [N_PLAYERS];
  logic [COORD_W-1:0] py [N_PLAYERS];
  logic [COORD_W-1:0] sx [N_PLAYERS];
  logic [COORD_W-1:0] sy [N_PLAYERS];
  logic [2:0]         dir_a [N_PLAYERS];

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
    assign sx[g] = start_x[g*COORD_W +: COORD_W];
    assign sy[g] = start_y[g*COORD_W +: COORD_W];
    assign dir_a[g] = direction[g*3 +: 3];
    assign pos_x[g*COORD_W +: COORD_W] = px[g];
    assign pos_y[g*COORD_W +: COORD_W] = py[g];
  end

  assign busy      = (state == S_EVAL) || (state == S_READ) || (state == S_CHECK);
  assign dbg_state = state;

  logic [2:0]         cur_dir;
  logic [COORD_W-1:0] cur_x, cur_y, tx, ty;
  logic               moving, oob, conflict, skip, last;

  always_comb begin
    cur_dir  = dir_a[idx];
    cur_x    = px[idx];
    cur_y    = py[idx];
    tx       = cur_x;
    ty       = cur_y;
    moving   = 1'b1;
    conflict = 1'b0;
    case (cur_dir)
      DIR_RIGHT: tx = cur_x + ONE;
      DIR_LEFT:  tx = cur_x - ONE;
      DIR_DOWN:  ty = cur_y + ONE;
      DIR_UP:    ty = cur_y - ONE;
      default:   moving = 1'b0;
    endcase
`ifdef CONTROL_WRAP_EN
    if (cur_dir == DIR_RIGHT && tx == MAP_W_C) tx = '0;
    if (cur_dir == DIR_LEFT  && cur_x == '0)   tx = MAP_W_C - ONE;
    if (cur_dir == DIR_DOWN  && ty == MAP_H_C) ty = '0;
    if (cur_dir == DIR_UP    && cur_y == '0)   ty = MAP_H_C - ONE;
`endif
    // Underflow of 0-1 lands at all-ones, so it is caught by the same compare.
    oob = (tx >= MAP_W_C) || (ty >= MAP_H_C);
    for (int j = 0; j < N_PLAYERS; j++) begin
      if (IDX_W'(j) != idx && enable[j] && px[j] == tx && py[j] == ty) conflict = 1'b1;
    end
    skip = !enable[idx] || collision[idx] || !moving;
    last = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tick_pend     <= 1'b0;
      idx           <= '0;
      lat_cnt       <= '0;
      collision     <= '0;
      step_done     <= 1'b0;
      map.map_rd_en <= 1'b0;
      map.map_rd_x  <= '0;
      map.map_rd_y  <= '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        px[k] <= '0;
        py[k] <= '0;
      end
    end else begin
      map.map_rd_en <= 1'b0;
      step_done     <= 1'b0;
      if (start) begin
        // Restart abandons any scan in flight; a pending tile read is never sampled.
        state     <= S_WAIT_TICK;
        cnt       <= '0;
        tick_pend <= 1'b0;
        idx       <= '0;
        collision <= '0;
        for (int k = 0; k < N_PLAYERS; k++) begin
          px[k] <= sx[k];
          py[k] <= sy[k];
        end
      end else begin
        if (state != S_IDLE) begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            tick_pend <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        case (state)
          S_IDLE: ;
          S_WAIT_TICK: begin
            if (tick_pend) begin
              tick_pend <= 1'b0;
              idx       <= '0;
              state     <= S_EVAL;
            end
          end
          S_EVAL: begin
            if (!skip && !oob && !conflict) begin
              map.map_rd_en <= 1'b1;
              map.map_rd_x  <= tx;
              map.map_rd_y  <= ty;
              lat_cnt       <= '0;
              state         <= S_READ;
            end else begin
              if (!skip) collision[idx] <= 1'b1;
              if (last) begin
                step_done <= 1'b1;
                state     <= S_DONE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= S_EVAL;
              end
            end
          end
          S_READ: begin
            if (lat_cnt == LAT_LAST) state <= S_CHECK;
            else lat_cnt <= lat_cnt + 2'd1;
          end
          S_CHECK: begin
            // map_rd_x/y still hold the target issued in EVAL.
            if (map.map_rd_tile == TILE_EMPTY) begin
              px[idx] <= map.map_rd_x;
              py[idx] <= map.map_rd_y;
            end else begin
              collision[idx] <= 1'b1;
            end
            if (last) begin
              step_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_EVAL;
            end
          end
          S_DONE: state <= halt ? S_IDLE : S_WAIT_TICK;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_player_control.sv
// Scoreboard bench for multi_player_control: 16x12 map with a FRAME border, two players.
// Expected results are pushed per scan and popped by a monitor on every step_done.
module tb_multi_player_control;
  localparam int N = 2, CW = 8, MW = 16, MH = 12, TD = 4, LAT = 1;
  localparam int W = CW*4 + N + 4;
  localparam logic [2:0] D_WAIT = 3'd0, D_R = 3'd1, D_L = 3'd2, D_D = 3'd3, D_U = 3'd4;
  localparam logic [2:0] T_EMPTY = 3'd0, T_FRAME = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_READ = 3'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic [N-1:0]      enable = '0;
  logic [N*3-1:0]    direction = '0;
  logic [N*CW-1:0]   start_x = '0;
  logic [N*CW-1:0]   start_y = '0;
  logic [N*CW-1:0]   pos_x, pos_y;
  logic [N-1:0]      collision;
  logic              step_done, busy;
  logic [2:0]        dbg_state;

  multi_player_control_if #(.COORD_W(CW), .TILE_W(3)) map_bus ();

  multi_player_control #(
    .N_PLAYERS(N), .COORD_W(CW), .MAP_W(MW), .MAP_H(MH), .TICK_DIV(TD), .MAP_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .enable(enable),
    .direction(direction), .start_x(start_x), .start_y(start_y), .map(map_bus),
    .pos_x(pos_x), .pos_y(pos_y), .collision(collision), .step_done(step_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Map store: border is FRAME, interior EMPTY, plus one optional FRAME override.
  logic          ov_en = 1'b0;
  logic [CW-1:0] ov_x = '0, ov_y = '0;

  function automatic logic [2:0] tile_at(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (ov_en && x == ov_x && y == ov_y) return T_FRAME;
    if (x == 8'd0 || y == 8'd0 || x >= 8'(MW-1) || y >= 8'(MH-1)) return T_FRAME;
    return T_EMPTY;
  endfunction

  always @(posedge clk)
    if (map_bus.map_rd_en) map_bus.map_rd_tile <= tile_at(map_bus.map_rd_x, map_bus.map_rd_y);

  int            errors = 0;
  int            checks = 0;
  int            step_no = 0;
  logic [W-1:0]  exp_q[$];
  logic [3:0]    rd_cnt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int x0, input int y0, input int x1, input int y1,
                          input int coll, input int reads);
    exp_q.push_back({8'(x1), 8'(x0), 8'(y1), 8'(y0), 2'(coll), 4'(reads)});
  endtask

  // Monitor: counts read strobes per scan and scores each step_done.
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!rst) begin
      rd_cnt = '0;
    end else begin
      if (map_bus.map_rd_en) rd_cnt = rd_cnt + 4'd1;
      if (start) rd_cnt = '0;
      if (step_done) begin
        step_no++;
        checks++;
        got = {pos_x, pos_y, collision, rd_cnt};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL step%0d unexpected step_done pos_x=%h pos_y=%h coll=%b", step_no,
                   pos_x, pos_y, collision);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL step%0d got pos_x=%h pos_y=%h coll=%b reads=%0d exp pos_x=%h pos_y=%h coll=%b reads=%0d",
                     step_no, got[W-1 -: 16], got[W-17 -: 16], got[5:4], got[3:0],
                     exp[W-1 -: 16], exp[W-17 -: 16], exp[5:4], exp[3:0]);
          end
        end
        rd_cnt = '0;
      end
    end
  end

  // Inputs change just after a falling edge; start is sampled at exactly one rising edge.
  task automatic do_start(input int x0, input int y0, input int x1, input int y1,
                          input logic [2:0] d0, input logic [2:0] d1,
                          input logic [1:0] en, input logic h);
    @(negedge clk); #1;
    start_x   = {8'(x1), 8'(x0)};
    start_y   = {8'(y1), 8'(y0)};
    direction = {d1, d0};
    enable    = en;
    halt      = h;
    start     = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Let n scans complete, then park the DUT in IDLE via halt on the last one.
  task automatic wait_case(input string name, input int n);
    int guard = 0;
    if (n > 1) begin
      while (exp_q.size() > 1 && guard < 500) begin
        @(posedge clk);
        guard++;
      end
      #1 halt = 1'b1;
    end
    while ((exp_q.size() != 0 || dbg_state != S_IDLE) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d state=%0d", name, exp_q.size(), dbg_state);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    int guard = 0;
    while (dbg_state != s && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (dbg_state != s) begin
      errors++;
      $display("FAIL wait_state got=%0d exp=%0d", dbg_state, s);
    end
  endtask

  initial begin
    int cyc;
    #12;
    check("reset_outputs", 64'({pos_x, pos_y, collision, step_done, map_bus.map_rd_en, busy}), 64'd0);
    @(negedge clk); #1 rst = 1'b1;

    // P0 walks right across empty tiles, one read per scan.
    push_exp(6, 5, 10, 8, 0, 1);
    push_exp(7, 5, 10, 8, 0, 1);
    push_exp(8, 5, 10, 8, 0, 1);
    do_start(5, 5, 10, 8, D_R, D_WAIT, 2'b01, 1'b0);
    wait_case("walk_right", 3);

    // Wall tile: sticky collision, no further reads.
    ov_en = 1'b1; ov_x = 8'd6; ov_y = 8'd5;
    push_exp(5, 5, 10, 8, 1, 1);
    push_exp(5, 5, 10, 8, 1, 0);
    do_start(5, 5, 10, 8, D_R, D_WAIT, 2'b01, 1'b0);
    wait_case("wall", 2);
    ov_en = 1'b0;

    // Head-on swap: both target the other's held position.
    push_exp(3, 3, 4, 3, 3, 0);
    push_exp(3, 3, 4, 3, 3, 0);
    do_start(3, 3, 4, 3, D_R, D_L, 2'b11, 1'b0);
    wait_case("swap", 2);

    // Left from column 0.
`ifdef CONTROL_WRAP_EN
    push_exp(0, 2, 10, 8, 1, 1);
`else
    push_exp(0, 2, 10, 8, 1, 0);
`endif
    do_start(0, 2, 10, 8, D_L, D_WAIT, 2'b01, 1'b1);
    wait_case("left_edge", 1);

    // P0 hits the bottom frame row, P1 moves up.
    push_exp(10, 10, 2, 2, 1, 2);
    do_start(10, 10, 2, 3, D_D, D_U, 2'b11, 1'b1);
    wait_case("down_up", 1);

    // Right off the last column; P1 moves left.
`ifdef CONTROL_WRAP_EN
    push_exp(15, 4, 3, 4, 1, 2);
`else
    push_exp(15, 4, 3, 4, 1, 1);
`endif
    do_start(15, 4, 4, 4, D_R, D_L, 2'b11, 1'b1);
    wait_case("right_edge", 1);

    // Same target: lower index moves first, higher index collides with it.
    push_exp(7, 6, 8, 6, 2, 1);
    do_start(6, 6, 8, 6, D_R, D_L, 2'b11, 1'b1);
    wait_case("same_target", 1);

    // A disabled player is not an obstacle.
    push_exp(6, 5, 6, 5, 0, 1);
    do_start(5, 5, 6, 5, D_R, D_L, 2'b01, 1'b1);
    wait_case("disabled_p1", 1);

    // Invalid direction codes behave as WAIT.
    push_exp(5, 5, 10, 8, 0, 0);
    do_start(5, 5, 10, 8, 3'd7, 3'd5, 2'b11, 1'b1);
    wait_case("invalid_dir", 1);

    // start during READ: the outstanding tile is ignored and positions reload.
    push_exp(9, 10, 10, 8, 0, 1);
    do_start(5, 5, 10, 8, D_R, D_WAIT, 2'b01, 1'b0);
    wait_state(S_READ);
    #1;
    start_x = {8'd10, 8'd9};
    start_y = {8'd8, 8'd9};
    direction = {D_WAIT, D_D};
    halt = 1'b1;
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    check("restart_pos_x", 64'(pos_x), 64'(16'h0A09));
    check("restart_pos_y", 64'(pos_y), 64'(16'h0809));
    check("restart_coll", 64'(collision), 64'd0);
    check("restart_rd_en", 64'(map_bus.map_rd_en), 64'd0);
    check("restart_state", 64'(dbg_state), 64'(S_WAIT));
    cyc = 0;
    while (!step_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("restart_latency_ge4", 64'(cyc >= 4 && cyc < 100), 64'd1);
    wait_case("restart", 1);

    // Asynchronous reset in the middle of a scan.
    do_start(5, 5, 10, 8, D_R, D_WAIT, 2'b01, 1'b0);
    wait_state(S_READ);
    #2 rst = 1'b0;
    #1;
    check("arst_pos_x", 64'(pos_x), 64'd0);
    check("arst_pos_y", 64'(pos_y), 64'd0);
    check("arst_coll", 64'(collision), 64'd0);
    check("arst_step_done", 64'(step_done), 64'd0);
    check("arst_rd_en", 64'(map_bus.map_rd_en), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("leftover_expect", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
